// File: rtl/uart_ctrl_pkg.sv
// Shared types and encodings for the UART transmit scheduler and the
// transmit unit it feeds.
package uart_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int PAR_W  = 2;
  localparam int BAUD_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    BUSY     = 3'd2,
    COMPLETE = 3'd3,
    ERR      = 3'd4
  } state_e;

  // Plain constants for the state register, matching state_e encodings.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_BUSY     = 3'd2;
  localparam logic [2:0] ST_COMPLETE = 3'd3;
  localparam logic [2:0] ST_ERR      = 3'd4;

  // parity_type encoding understood by the transmit unit.
  localparam logic [PAR_W-1:0] PARITY_NONE = 2'b00;
  localparam logic [PAR_W-1:0] PARITY_ODD  = 2'b01;
  localparam logic [PAR_W-1:0] PARITY_EVEN = 2'b10;

  // baud_rate encoding understood by the transmit unit.
  localparam logic [BAUD_W-1:0] BAUD_2400  = 2'b00;
  localparam logic [BAUD_W-1:0] BAUD_4800  = 2'b01;
  localparam logic [BAUD_W-1:0] BAUD_9600  = 2'b10;
  localparam logic [BAUD_W-1:0] BAUD_19200 = 2'b11;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmit-unit-side signals of the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import uart_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*PAR_W-1:0]  req_parity;
  logic [NUM_REQ*BAUD_W-1:0] req_baud;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic                      tx_send;
  logic [DATA_W-1:0]         tx_data;
  logic [PAR_W-1:0]          tx_parity_type;
  logic [BAUD_W-1:0]         tx_baud_rate;
  logic                      tx_active;
  logic                      tx_done;
  logic                      busy;

  // The scheduler itself.
  modport slave (
    input  req, req_data, req_parity, req_baud, tx_active, tx_done,
    output grant, req_done, req_err, tx_send, tx_data, tx_parity_type,
           tx_baud_rate, busy
  );

  // Requesters plus transmit unit (or a bench standing in for them).
  modport master (
    output req, req_data, req_parity, req_baud, tx_active, tx_done,
    input  grant, req_done, req_err, tx_send, tx_data, tx_parity_type,
           tx_baud_rate, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  function automatic logic [IDX_W-1:0] wrap_pos(input logic [IDX_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDX_W'(s);
  endfunction

  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   idx_s;
  logic               found_s;

  // Scan from the pointer and keep the first requester found.
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req_i[wrap_pos(ptr_i, k)]) begin
        found_s = 1'b1;
        idx_s   = wrap_pos(ptr_i, k);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt_s[idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign gnt_o   = gnt_s;
  assign idx_o   = idx_s;
  assign valid_o = found_s;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit unit among NUM_REQ byte sources: round-robin
// grant, send/active/done handshake, per-requester done/timeout pulses.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 21
) (
  input logic                clock,
  input logic                reset_n,
  uart_tx_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               send_q, send_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PAR_W-1:0]   par_q, par_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_valid_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  // Transaction FSM: next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    send_d  = send_q;
    data_d  = data_q;
    par_d   = par_q;
    baud_d  = baud_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d = ST_START;
          win_d   = arb_idx_s;
          grant_d = arb_gnt_s;
          data_d  = bus.req_data[int'(arb_idx_s)*DATA_W +: DATA_W];
          par_d   = bus.req_parity[int'(arb_idx_s)*PAR_W +: PAR_W];
          baud_d  = bus.req_baud[int'(arb_idx_s)*BAUD_W +: BAUD_W];
          send_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // tx_done is deliberately not looked at here: it may be stale.
        if (bus.tx_active) begin
          state_d = ST_BUSY;
          send_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          send_d  = 1'b0;
          grant_d = '0;
          err_d   = grant_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BUSY: begin
        if (!bus.tx_active && bus.tx_done) begin
          state_d = ST_COMPLETE;
          grant_d = '0;
          done_d  = grant_q;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          send_d  = 1'b0;
          grant_d = '0;
          err_d   = grant_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_COMPLETE, ST_ERR: begin
        state_d = ST_IDLE;
        ptr_d   = (win_q == IDX_MAX) ? '0 : (win_q + IDX_ONE);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        send_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= '0;
      baud_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      send_q  <= send_d;
      data_q  <= data_d;
      par_q   <= par_d;
      baud_q  <= baud_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.req_done       = done_q;
  assign bus.req_err        = err_q;
  assign bus.tx_send        = send_q;
  assign bus.tx_data        = data_q;
  assign bus.tx_parity_type = par_q;
  assign bus.tx_baud_rate   = baud_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Multi-requester front end that shares one UART transmit unit (baud generator + parity + PISO) between NUM_REQ byte sources. Selects a requester round-robin and drives that requester's byte, parity type and baud selection onto the transmit unit. Runs the send/active/done handshake and reports per-requester completion or timeout. Sits between protocol/CPU-side producers and the transmit unit inside the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 1048576, clock cycles allowed per START or BUSY phase before abort
CNT_W, 21, width of the timeout counter; must be at least clog2(TIMEOUT_CYC)+1

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; held until that requester's done or err pulse
req_data  in  NUM_REQ*8  byte per requester; slice i = bits [8i+7:8i]
req_parity  in  NUM_REQ*2  parity_type per requester
req_baud  in  NUM_REQ*2  baud_rate selection per requester
grant  out  NUM_REQ  one-hot; held for the whole transaction
req_done  out  NUM_REQ  one-cycle pulse; granted byte fully transmitted
req_err  out  NUM_REQ  one-cycle pulse; granted transaction timed out
tx_send  out  1  to transmit unit send
tx_data  out  8  to transmit unit data_in
tx_parity_type  out  2  to transmit unit parity_type
tx_baud_rate  out  2  to transmit unit baud_rate
tx_active  in  1  transmit unit active_flag
tx_done  in  1  transmit unit done_flag
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; grant=0, req_done=0, req_err=0, tx_send=0, tx_data=0, tx_parity_type=0, tx_baud_rate=0, busy=0; rr pointer=0; timeout counter=0.
- IDLE: if req != 0, register winner index, latch its data/parity/baud into the tx_* output registers, set grant one-hot, then go to START. Latency from req rising to grant and tx_* valid is 1 cycle. tx_* values stay frozen until the next grant.
- Arbitration: round-robin. Search starts at the pointer and wraps modulo NUM_REQ; the first set bit wins. The pointer becomes winner+1 (wrapping to 0) only on COMPLETE or ERR.
- START: tx_send=1 and the counter increments. When tx_active==1, drop tx_send, clear the counter and go to BUSY. Any stale tx_done high in this state is ignored. If the counter reaches TIMEOUT_CYC, go to ERR.
- BUSY: tx_send=0 and the counter increments. When tx_active==0 && tx_done==1, go to COMPLETE. If the counter reaches TIMEOUT_CYC, go to ERR.
- COMPLETE (1 cycle): req_done[winner]=1, grant=0, advance the pointer, then go to IDLE.
- ERR (1 cycle): req_err[winner]=1, grant=0, tx_send=0, advance the pointer, then go to IDLE.
- Minimum back-to-back spacing: IDLE is visited for at least 1 cycle between transactions.
- Requester behaviour during a transaction:
  - A requester dropping req mid-transaction does not abort it; completion is still pulsed.
  - Non-granted req changes are only sampled in IDLE.
- Simultaneous tx_active rising and timeout in START: active wins, go to BUSY.
- Simultaneous done and timeout in BUSY: done wins, go to COMPLETE.
- A req bit that is still high in IDLE after its own done pulse is treated as a new request. Requesters drop req in the cycle after req_done.
- Reset asserted mid-frame: tx_send drops immediately. The transmit unit shares reset_n, so no partial-frame recovery is needed.

Decomposition:
- Package uart_ctrl_pkg:
  - state enum typedef {IDLE, START, BUSY, COMPLETE, ERR}
  - localparam widths for data (8), parity (2) and baud (2)
  - parity_type and baud_rate encoding constants shared with the transmit unit
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot winner plus index from req and the pointer; pointer register kept in the parent.

Test Plan:
- Single request: req=4'b0001, data 8'hA5, parity 2'b01, baud 2'b10 → grant=0001 after 1 cycle; tx_data=A5, tx_parity_type=01, tx_baud_rate=10; tx_send high until tx_active; req_done[0] one pulse after done_flag; serial line carries A5.
- Round-robin fairness: req=4'b1111 held, bytes 11/22/33/44 → grant order 0,1,2,3,0. No requester is granted twice before the others.
- Wrap-around: pointer=3 after serving req2; req=4'b0101 → req0 is granted (search wraps), then req2.
- Timeout: tx_active tied 0, TIMEOUT_CYC=16 → req_err pulses exactly 16 cycles after START entry; tx_send falls and the state returns to IDLE.
- Stale done: tx_done held 1 before the transaction starts → no req_done until tx_active has risen and fallen with done high.
- Reset mid-frame: assert reset_n=0 during BUSY → all outputs 0 asynchronously; after release, req=0001 is served from pointer 0 normally.
